// File: rtl/ps2_keymatrix.sv
// PS/2 set-2 keyboard receiver feeding an emulated C64 8x8 key matrix for CIA1.
// Optional `KEYMATRIX_JOY_EMU_EN: keypad 8/2/4/6/0 drive the active-low joy port.
//
// state    | meaning
// S_IDLE   | waiting for a start bit (0) on a ps2_clk falling edge
// S_DATA   | shifting 8 data bits, LSB first
// S_PARITY | capturing the odd-parity bit
// S_STOP   | checking stop bit and parity, pulsing byte_valid on success
module ps2_keymatrix #(
  parameter int TIMEOUT_CYCLES = 8000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] keyboard_row,
  output logic [7:0] keyboard_col,
  output logic       restore,
  output logic [4:0] joy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]      clk_sync, data_sync;
  logic            clk_prev, fall, bit_in;
  logic [1:0]      state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit, byte_valid;
  logic [TW-1:0]   tmo_cnt;
  logic            ext_f, brk_f, restore_q;
  logic [4:0]      joy_q;
  logic [7:0][7:0] key_mat;
  logic [6:0]      km;
  logic [7:0]      col_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[1];
  assign bit_in = data_sync[1];

  // tmo_cnt reaches zero TIMEOUT_CYCLES clocks after the last falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      par_bit    <= 1'b0;
      tmo_cnt    <= TMO_LOAD;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (fall) tmo_cnt <= TMO_LOAD;
      else if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;

      if (state != S_IDLE && !fall && tmo_cnt == '0) begin
        state <= S_IDLE;
      end else if (fall) begin
        case (state)
          S_IDLE: if (!bit_in) begin
            state   <= S_DATA;
            bit_cnt <= 3'd0;
          end
          S_DATA: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= bit_in;
            state   <= S_STOP;
          end
          default: begin
            state      <= S_IDLE;
            byte_valid <= bit_in & (^{shreg, par_bit});
          end
        endcase
      end
    end
  end

  // {ext, code} -> {valid, row, col}
  function automatic logic [6:0] key_map(input logic [8:0] k);
    case (k)
      9'h066: key_map = {1'b1, 3'd0, 3'd0};  9'h05A: key_map = {1'b1, 3'd0, 3'd1};
      9'h174: key_map = {1'b1, 3'd0, 3'd2};  9'h083: key_map = {1'b1, 3'd0, 3'd3};
      9'h005: key_map = {1'b1, 3'd0, 3'd4};  9'h004: key_map = {1'b1, 3'd0, 3'd5};
      9'h003: key_map = {1'b1, 3'd0, 3'd6};  9'h172: key_map = {1'b1, 3'd0, 3'd7};
      9'h15A: key_map = {1'b1, 3'd0, 3'd1};
      9'h026: key_map = {1'b1, 3'd1, 3'd0};  9'h01D: key_map = {1'b1, 3'd1, 3'd1};
      9'h01C: key_map = {1'b1, 3'd1, 3'd2};  9'h025: key_map = {1'b1, 3'd1, 3'd3};
      9'h01A: key_map = {1'b1, 3'd1, 3'd4};  9'h01B: key_map = {1'b1, 3'd1, 3'd5};
      9'h024: key_map = {1'b1, 3'd1, 3'd6};  9'h012: key_map = {1'b1, 3'd1, 3'd7};
      9'h02E: key_map = {1'b1, 3'd2, 3'd0};  9'h02D: key_map = {1'b1, 3'd2, 3'd1};
      9'h023: key_map = {1'b1, 3'd2, 3'd2};  9'h036: key_map = {1'b1, 3'd2, 3'd3};
      9'h021: key_map = {1'b1, 3'd2, 3'd4};  9'h02B: key_map = {1'b1, 3'd2, 3'd5};
      9'h02C: key_map = {1'b1, 3'd2, 3'd6};  9'h022: key_map = {1'b1, 3'd2, 3'd7};
      9'h03D: key_map = {1'b1, 3'd3, 3'd0};  9'h035: key_map = {1'b1, 3'd3, 3'd1};
      9'h034: key_map = {1'b1, 3'd3, 3'd2};  9'h03E: key_map = {1'b1, 3'd3, 3'd3};
      9'h032: key_map = {1'b1, 3'd3, 3'd4};  9'h033: key_map = {1'b1, 3'd3, 3'd5};
      9'h03C: key_map = {1'b1, 3'd3, 3'd6};  9'h02A: key_map = {1'b1, 3'd3, 3'd7};
      9'h046: key_map = {1'b1, 3'd4, 3'd0};  9'h043: key_map = {1'b1, 3'd4, 3'd1};
      9'h03B: key_map = {1'b1, 3'd4, 3'd2};  9'h045: key_map = {1'b1, 3'd4, 3'd3};
      9'h03A: key_map = {1'b1, 3'd4, 3'd4};  9'h042: key_map = {1'b1, 3'd4, 3'd5};
      9'h044: key_map = {1'b1, 3'd4, 3'd6};  9'h031: key_map = {1'b1, 3'd4, 3'd7};
      9'h079: key_map = {1'b1, 3'd5, 3'd0};  9'h04D: key_map = {1'b1, 3'd5, 3'd1};
      9'h04B: key_map = {1'b1, 3'd5, 3'd2};  9'h04E: key_map = {1'b1, 3'd5, 3'd3};
      9'h049: key_map = {1'b1, 3'd5, 3'd4};  9'h052: key_map = {1'b1, 3'd5, 3'd5};
      9'h054: key_map = {1'b1, 3'd5, 3'd6};  9'h041: key_map = {1'b1, 3'd5, 3'd7};
      9'h05D: key_map = {1'b1, 3'd6, 3'd0};  9'h05B: key_map = {1'b1, 3'd6, 3'd1};
      9'h04C: key_map = {1'b1, 3'd6, 3'd2};  9'h16C: key_map = {1'b1, 3'd6, 3'd3};
      9'h059: key_map = {1'b1, 3'd6, 3'd4};  9'h055: key_map = {1'b1, 3'd6, 3'd5};
      9'h04A: key_map = {1'b1, 3'd6, 3'd7};
      9'h016: key_map = {1'b1, 3'd7, 3'd0};  9'h00E: key_map = {1'b1, 3'd7, 3'd1};
      9'h014: key_map = {1'b1, 3'd7, 3'd2};  9'h114: key_map = {1'b1, 3'd7, 3'd2};
      9'h01E: key_map = {1'b1, 3'd7, 3'd3};  9'h029: key_map = {1'b1, 3'd7, 3'd4};
      9'h011: key_map = {1'b1, 3'd7, 3'd5};  9'h015: key_map = {1'b1, 3'd7, 3'd6};
      9'h076: key_map = {1'b1, 3'd7, 3'd7};
      default: key_map = 7'd0;
    endcase
  endfunction

  assign km = key_map({ext_f, shreg});

`ifdef KEYMATRIX_JOY_EMU_EN
  logic [3:0] jm;
  always_comb begin
    jm = 4'd0;
    case (shreg)
      8'h75: jm = {1'b1, 3'd0};
      8'h72: jm = {1'b1, 3'd1};
      8'h6B: jm = {1'b1, 3'd2};
      8'h74: jm = {1'b1, 3'd3};
      8'h70: jm = {1'b1, 3'd4};
      default: jm = 4'd0;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_f     <= 1'b0;
      brk_f     <= 1'b0;
      restore_q <= 1'b0;
      joy_q     <= 5'h1F;
      key_mat   <= '0;
    end else if (byte_valid) begin
      if (shreg == 8'hE0) ext_f <= 1'b1;
      else if (shreg == 8'hF0) brk_f <= 1'b1;
      else begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
        if (shreg == 8'hAA || shreg == 8'h00 || shreg == 8'hFF) begin
          key_mat   <= '0;
          restore_q <= 1'b0;
          joy_q     <= 5'h1F;
        end else if (ext_f && shreg == 8'h7D) begin
          restore_q <= ~brk_f;
`ifdef KEYMATRIX_JOY_EMU_EN
        end else if (!ext_f && jm[3]) begin
          joy_q[jm[2:0]] <= brk_f;
`endif
        end else if (km[6]) begin
          key_mat[km[5:3]][km[2:0]] <= ~brk_f;
        end
      end
    end
  end

  always_comb begin
    col_next = 8'hFF;
    for (int r = 0; r < 8; r++)
      if (!keyboard_row[r]) col_next = col_next & ~key_mat[r];
  end

  always_ff @(posedge clk) begin
    if (reset) keyboard_col <= 8'hFF;
    else       keyboard_col <= col_next;
  end

  assign restore = restore_q;
  assign joy     = joy_q;

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Randomized bench for ps2_keymatrix against a byte-level key-state model.
module tb_ps2_keymatrix;

  localparam int TMO = 8000;
  localparam int H   = 4;
`ifdef KEYMATRIX_JOY_EMU_EN
  localparam bit JOY_EMU = 1'b1;
`else
  localparam bit JOY_EMU = 1'b0;
`endif

  logic       clk, reset, ps2_clk, ps2_data;
  logic [7:0] keyboard_row, keyboard_col;
  logic       restore;
  logic [4:0] joy;

  ps2_keymatrix #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keyboard_row(keyboard_row), .keyboard_col(keyboard_col),
    .restore(restore), .joy(joy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit ext; logic [7:0] code; int row; int col; } km_t;
  km_t keymap [15] = '{
    '{1'b0, 8'h5A, 0, 1}, '{1'b0, 8'h05, 0, 4}, '{1'b0, 8'h1C, 1, 2},
    '{1'b0, 8'h12, 1, 7}, '{1'b0, 8'h59, 6, 4}, '{1'b0, 8'h29, 7, 4},
    '{1'b0, 8'h76, 7, 7}, '{1'b0, 8'h1D, 1, 1}, '{1'b0, 8'h1B, 1, 5},
    '{1'b0, 8'h15, 7, 6}, '{1'b0, 8'h16, 7, 0}, '{1'b0, 8'h1A, 1, 4},
    '{1'b1, 8'h72, 0, 7}, '{1'b1, 8'h74, 0, 2}, '{1'b1, 8'h5A, 0, 1}};
  logic [7:0] mapped_pool [12] = '{8'h5A, 8'h05, 8'h1C, 8'h12, 8'h59, 8'h29,
                                   8'h76, 8'h1D, 8'h1B, 8'h15, 8'h16, 8'h1A};
  logic [7:0] unmapped_pool [5] = '{8'h7E, 8'h77, 8'h01, 8'h09, 8'h78};
  logic [7:0] joy_pool [5]      = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h70};
  logic [7:0] ext_pool [4]      = '{8'h72, 8'h74, 8'h5A, 8'h1C};

  bit         mdl_mat [8][8];
  bit         mdl_restore, mdl_ext, mdl_brk;
  logic [4:0] mdl_joy;
  logic [7:0] row_q;
  bit         chk_en;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    foreach (mdl_mat[r, c]) mdl_mat[r][c] = 1'b0;
    mdl_restore = 1'b0;
    mdl_joy     = 5'h1F;
    mdl_ext     = 1'b0;
    mdl_brk     = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int jidx;
    if (b == 8'hE0) mdl_ext = 1'b1;
    else if (b == 8'hF0) mdl_brk = 1'b1;
    else begin
      jidx = -1;
      for (int i = 0; i < 5; i++) if (joy_pool[i] == b) jidx = i;
      if (b == 8'hAA || b == 8'h00 || b == 8'hFF) begin
        foreach (mdl_mat[r, c]) mdl_mat[r][c] = 1'b0;
        mdl_restore = 1'b0;
        mdl_joy     = 5'h1F;
      end else if (mdl_ext && b == 8'h7D) begin
        mdl_restore = !mdl_brk;
      end else if (JOY_EMU && !mdl_ext && jidx >= 0) begin
        mdl_joy[jidx] = mdl_brk;
      end else begin
        foreach (keymap[i])
          if (keymap[i].ext == mdl_ext && keymap[i].code == b)
            mdl_mat[keymap[i].row][keymap[i].col] = !mdl_brk;
      end
      mdl_ext = 1'b0;
      mdl_brk = 1'b0;
    end
  endtask

  function automatic logic [7:0] exp_col();
    logic [7:0] e;
    e = 8'hFF;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++)
        if (!row_q[r] && mdl_mat[r][c]) e[c] = 1'b0;
    return e;
  endfunction

  always @(posedge clk) row_q <= keyboard_row;

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("model_col", keyboard_col, exp_col());
      chk("model_restore", {7'd0, restore}, {7'd0, mdl_restore});
      chk("model_joy", {3'd0, joy}, {3'd0, mdl_joy});
    end
  end

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    return {~bad_stop, ~(^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [7:0] b, input int n);
    logic [10:0] bits;
    bits = frame_bits(b, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) send_bit(bits[i]);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bits = frame_bits(b, bad_par, bad_stop);
    for (int i = 0; i < 10; i++) send_bit(bits[i]);
    chk_en = 1'b0;
    send_bit(bits[10]);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    if (!bad_par && !bad_stop) model_byte(b);
    chk_en = 1'b1;
  endtask

  task automatic sendf(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic sendr(input logic [7:0] b);
    send_frame(b, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 3);
  endtask

  function automatic logic [7:0] rand_row();
    logic [7:0] v;
    if ($urandom_range(0, 9) < 6) begin
      v = 8'hFF;
      v[$urandom_range(0, 7)] = 1'b0;
    end else v = 8'($urandom);
    return v;
  endfunction

  task automatic rand_event();
    int  sel;
    bit  brk;
    sel = $urandom_range(0, 99);
    brk = ($urandom_range(0, 2) == 0);
    if (sel < 6) sendr(8'hAA);
    else if (sel < 14) begin
      sendr(8'hE0); if (brk) sendr(8'hF0); sendr(8'h7D);
    end else if (sel < 24) begin
      if (brk) sendr(8'hF0); sendr(unmapped_pool[$urandom_range(0, 4)]);
    end else if (sel < 40) begin
      if (brk) sendr(8'hF0); sendr(joy_pool[$urandom_range(0, 4)]);
    end else if (sel < 50) begin
      sendr(8'hE0); if (brk) sendr(8'hF0); sendr(ext_pool[$urandom_range(0, 3)]);
    end else begin
      if (brk) sendr(8'hF0); sendr(mapped_pool[$urandom_range(0, 11)]);
    end
  endtask

  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; keyboard_row = 8'hFF;
    chk_en = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_col", keyboard_col, 8'hFF);
    chk("reset_restore", {7'd0, restore}, 8'h00);
    chk("reset_joy", {3'd0, joy}, 8'h1F);
    reset = 1'b0;
    chk_en = 1'b1;

    // single key make/break
    keyboard_row = 8'hFD;
    sendf(8'h1C);
    chk("a_make", keyboard_col, 8'hFB);
    sendf(8'hF0); sendf(8'h1C);
    chk("a_break", keyboard_col, 8'hFF);

    // bad parity is discarded
    send_frame(8'h1C, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      keyboard_row = (i == 0) ? 8'hFD : (i == 1) ? 8'h00 : (i == 2) ? 8'hFE : 8'hFF;
      repeat (2) @(negedge clk);
      chk("bad_parity_col", keyboard_col, 8'hFF);
    end

    // partial frame then timeout
    send_bits(8'h29, 5);
    repeat (TMO + 1) @(negedge clk);
    keyboard_row = 8'h7F;
    sendf(8'h29);
    chk("timeout_space", keyboard_col, 8'hEF);

    // two keys on two rows, typematic repeat, break of unheld key, self-test clear
    sendf(8'h12); sendf(8'h29); sendf(8'h29);
    sendf(8'hF0); sendf(8'h1C);
    keyboard_row = 8'h7D;
    repeat (2) @(negedge clk);
    chk("two_keys", keyboard_col, 8'h6F);
    keyboard_row = 8'hFF;
    repeat (2) @(negedge clk);
    chk("no_row", keyboard_col, 8'hFF);
    sendf(8'hAA);
    keyboard_row = 8'h7D;
    repeat (2) @(negedge clk);
    chk("selftest_clear", keyboard_col, 8'hFF);

    // restore, then reset mid-frame
    sendf(8'hE0); sendf(8'h7D);
    chk("restore_make", {7'd0, restore}, 8'h01);
    sendf(8'hE0); sendf(8'hF0); sendf(8'h7D);
    chk("restore_break", {7'd0, restore}, 8'h00);
    sendf(8'hE0); sendf(8'h7D);
    keyboard_row = 8'hFD;
    sendf(8'h1C);
    chk("pre_reset_col", keyboard_col, 8'hFB);
    send_bits(8'h29, 4);
    chk_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midframe_reset_col", keyboard_col, 8'hFF);
    chk("midframe_reset_restore", {7'd0, restore}, 8'h00);
    chk("midframe_reset_joy", {3'd0, joy}, 8'h1F);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    chk_en = 1'b1;
    sendf(8'h1C);
    chk("post_reset_frame", keyboard_col, 8'hFB);
    sendf(8'hAA);

    // joystick emulation
    sendf(8'h75);
    chk("joy_up", {3'd0, joy}, JOY_EMU ? 8'h1E : 8'h1F);
    sendf(8'h70);
    chk("joy_fire", {3'd0, joy}, JOY_EMU ? 8'h0E : 8'h1F);
    sendf(8'hF0); sendf(8'h75);
    chk("joy_up_release", {3'd0, joy}, JOY_EMU ? 8'h0F : 8'h1F);
    keyboard_row = 8'h00;
    repeat (2) @(negedge clk);
    chk("joy_no_matrix", keyboard_col, 8'hFF);
    sendf(8'hAA);

    for (int ev = 0; ev < 200; ev++) begin
      rand_event();
      for (int k = 0; k < 3; k++) begin
        keyboard_row = rand_row();
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_keymatrix.md
PS2_KEYMATRIX -- requirements
Module: ps2_keymatrix

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 8000, clk cycles without a PS/2 falling edge before a partial frame is discarded.
REQ-002 clk  input  1  system clock (dot clock domain); all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 ps2_clk  input  1  PS/2 clock from host keyboard, asynchronous.
REQ-005 ps2_data  input  1  PS/2 data, asynchronous.
REQ-006 keyboard_row  input  8  CIA1 port A drive; a bit at 0 selects that matrix line.
REQ-007 keyboard_col  output  8  to CIA1 port B; active-low sensed columns.
REQ-008 restore  output  1  high while the RESTORE key is held.
REQ-009 joy  output  5  active-low joystick (up, down, left, right, fire = bits 0..4).

Function
REQ-010 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer; a frame bit is sampled on a detected synchronized ps2_clk falling edge.
REQ-011 Receiver FSM states: IDLE, DATA (8 bits, LSB first), PARITY, STOP.
- IDLE->DATA on start bit 0; a start bit of 1 stays IDLE.
REQ-012 A frame is accepted only with odd parity over data+parity and stop=1; otherwise discard it and return to IDLE.
REQ-013 A timeout counter SHALL reset on every falling edge; reaching TIMEOUT_CYCLES outside IDLE returns to IDLE, discarding the partial frame.
REQ-014 Decoder: byte E0 sets the ext flag; F0 sets the brk flag; any other byte is a code, after which both flags clear.
REQ-015 A code SHALL clear (brk=1) or set (brk=0) exactly one bit of a 64-bit key matrix indexed [row][col], one clk after the stop bit is accepted.
REQ-016 Required mappings (set-2 code -> row,col):
- 5A -> 0,1 (RETURN)
- 05 -> 0,4 (F1)
- 1C -> 1,2 (A)
- 12 -> 1,7 (LSHIFT)
- 59 -> 6,4 (RSHIFT)
- 29 -> 7,4 (SPACE)
- 76 -> 7,7 (RUN/STOP)
- Remaining keys follow the standard C64 layout.
- Unmapped codes SHALL be ignored.
REQ-017 E0 7D (PgUp) drives restore; it does not touch the matrix.
REQ-018 Codes AA (self-test OK), 00 and FF (overrun) SHALL clear the entire matrix, restore and joy state.
REQ-019 keyboard_col[c] SHALL be registered: 0 iff some row r has keyboard_row[r]=0 and matrix[r][c]=1; latency one clk from a row or matrix change.
REQ-020 If a row change and a matrix update occur in the same cycle, the next-cycle keyboard_col SHALL reflect both.
REQ-021 Repeated make codes (typematic) SHALL be idempotent; a break for a key not held is a no-op.
REQ-022 No ghosting emulation is required.

Reset
REQ-023 While reset is high:
- FSM = IDLE; flags, timeout counter and matrix cleared.
- keyboard_col = FF, restore = 0, joy = 1F.
- Applies even mid-frame; the partial frame is discarded.

Configuration
REQ-024 Macro KEYMATRIX_JOY_EMU_EN.
- Defined: keypad codes 75/72/6B/74 (8/2/4/6) drive joy up/down/left/right and 70 (keypad 0) drives fire, active-low, and bypass the matrix.
- Undefined: joy is held at 1F and those codes map as ordinary unmapped keys (ignored).

Verification
REQ-025 Frame 1C, then keyboard_row=FD -> keyboard_col=FB; then F0 1C -> keyboard_col=FF.
REQ-026 Frame 1C with even parity -> matrix unchanged, keyboard_col=FF for every row pattern.
REQ-027 Send 5 bits of a frame, idle TIMEOUT_CYCLES+1 clk, then a valid 29 frame with keyboard_row=7F -> keyboard_col=EF.
REQ-028 Hold 12 and 29, keyboard_row=7D -> keyboard_col=6F; keyboard_row=FF -> keyboard_col=FF; then frame AA -> all released.
REQ-029 E0 7D -> restore=1; E0 F0 7D -> restore=0; assert reset mid-frame -> all outputs at their reset values next cycle.
REQ-030 With KEYMATRIX_JOY_EMU_EN: frame 75 -> joy=1E; frame 70 -> joy=0E; F0 75 -> joy=0F; without the macro, joy=1F throughout.
